// File: rtl/scan_decoder.sv
// Registered N-to-2^N select-line decoder with programmable active level.
// Direct mode decodes CodedInput; scan mode steps a counter through 0..Last.
module scan_decoder #(
  parameter int N          = 3,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int DIVIDER    = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              Mode,
  input  logic [N-1:0]      CodedInput,
  input  logic [N-1:0]      Last,
  output logic [2**N-1:0]   DecodedOutput,
  output logic [N-1:0]      Index,
  output logic              Wrap
);

  localparam int            W        = 2**N;
  localparam int            DW       = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIVIDER - 1);
  localparam logic [W-1:0]  INACTIVE = ACTIVE_LOW ? {W{1'b1}} : {W{1'b0}};

  function automatic logic [W-1:0] decode(input logic [N-1:0] code);
    logic [W-1:0] one_hot;
    one_hot       = '0;
    one_hot[code] = 1'b1;
    return ACTIVE_LOW ? ~one_hot : one_hot;
  endfunction

  logic [N-1:0]  cnt_q, cnt_d;
  logic [DW-1:0] div_q, div_d;
  logic [W-1:0]  out_q, out_d;
  logic [N-1:0]  index_q, index_d;
  logic          wrap_q, wrap_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    cnt_d   = cnt_q;
    div_d   = div_q;
    out_d   = INACTIVE;
    index_d = index_q;
    wrap_d  = 1'b0;

    if (!Mode) begin
      cnt_d   = '0;
      div_d   = '0;
      index_d = CodedInput;
      if (Enable) out_d = decode(CodedInput);
    end else if (Enable) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        // Comparing with >= makes a Last lowered below the count fold back to 0.
        cnt_d  = (cnt_q < Last) ? cnt_q + 1'b1 : '0;
        wrap_d = (cnt_d == '0) && (cnt_q != '0);
      end else begin
        div_d = div_q + 1'b1;
      end
      index_d = cnt_d;
      out_d   = decode(cnt_d);
    end
  end

  // NOTE: reset is synchronous and active-high, so it is only looked at inside the clocked branch.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      // NOTE: state uses non-blocking assignments so all registers update together at the edge.
      cnt_q   <= '0;
      div_q   <= '0;
      out_q   <= INACTIVE;
      index_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      out_q   <= out_d;
      index_q <= index_d;
      wrap_q  <= wrap_d;
    end
  end

  assign DecodedOutput = out_q;
  assign Index         = index_q;
  assign Wrap          = wrap_q;

endmodule
